// File: rtl/rshift_pkg.sv
// Shared types and defaults for the right_shift_sequencer slice.
package rshift_pkg;

    typedef enum logic {S_IDLE, S_EMIT} rshift_state_t;

    localparam int RSHIFT_N_DEFAULT = 3;

endpackage

// File: rtl/param_right_shifter.sv
// Combinational logical right shifter: result = num >> shift, vacated MSBs zero.
module param_right_shifter #(
    parameter int N = 3
) (
    input  logic [2**N-1:0] num,
    input  logic [N-1:0]    shift,
    output logic [2**N-1:0] result
);

    assign result = num >> shift;

endmodule

// File: rtl/right_shift_sequencer.sv
// Handshaked, registered front-end for param_right_shifter with single-beat and sweep modes.
// Define RSHIFT_STICKY_EN to add out_sticky (OR of the bits shifted out of each beat).
module right_shift_sequencer
    import rshift_pkg::*;
#(
    parameter int N = RSHIFT_N_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] in_num,
    input  logic [N-1:0]    in_shift,
    input  logic            in_sweep,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2**N-1:0] out_result,
    output logic [N-1:0]    out_shift,
`ifdef RSHIFT_STICKY_EN
    output logic            out_sticky,
`endif
    output logic            out_last
);

    localparam int W = 2**N;

    rshift_state_t  state_q, state_d;
    logic [W-1:0]   num_q, num_d;
    logic [N-1:0]   shift_q, shift_d;
    logic           sweep_q, sweep_d;
    logic [W-1:0]   result_q, result_d;
    logic           accept, take;

    assign out_valid  = (state_q == S_EMIT);
    assign out_last   = out_valid && (!sweep_q || (shift_q == '1));
    assign out_result = result_q;
    assign out_shift  = shift_q;
    assign in_ready   = !out_valid || (out_ready && out_last);
    assign accept     = in_valid && in_ready;
    assign take       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        shift_d = shift_q;
        sweep_d = sweep_q;
        if (accept) begin
            state_d = S_EMIT;
            num_d   = in_num;
            shift_d = in_shift;
            sweep_d = in_sweep;
        end else if (take && !out_last) begin
            shift_d = shift_q + N'(1);
        end else if (take) begin
            state_d = S_IDLE;
        end
    end

    // Shifter sees the next-cycle operands so each result lands in the same edge as its shift.
    param_right_shifter #(.N(N)) u_shifter (
        .num    (num_d),
        .shift  (shift_d),
        .result (result_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            shift_q  <= '0;
            sweep_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            shift_q  <= shift_d;
            sweep_q  <= sweep_d;
            result_q <= result_d;
        end
    end

`ifdef RSHIFT_STICKY_EN
    logic         sticky_q, sticky_d;
    logic [W-1:0] sticky_mask;

    assign sticky_mask = (W'(1) << shift_d) - W'(1);
    assign sticky_d    = |(num_d & sticky_mask);
    assign out_sticky  = sticky_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end
`endif

endmodule
